// File: rtl/cdb_reservation_station.sv
// cdb_reservation_station: reservation station that issues ops, snoops the CDB for operands and dispatches ready ops to a functional unit.
// Ports:
//   clk, rst_n                        - clock, asynchronous active-low reset
//   issue_valid/op/vj/vk/qj/qk        - issue request (q*=0 means v* holds the value)
//   issue_ready, issue_tag            - a free entry exists / tag it will receive
//   cdb_valid, cdb_tag, cdb_data      - common data bus broadcast (tag 0 is ignored)
//   fu_valid/op/a/b/tag, fu_ready     - dispatch handshake to the functional unit
// Optional feature: define RS_ISSUE_BYPASS_EN to capture a same-cycle CDB broadcast into the issuing entry.
module cdb_reservation_station #(
    parameter int NUM_ENTRIES = 3,
    parameter int TAG_BASE    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [2:0]  issue_op,
    input  logic [31:0] issue_vj,
    input  logic [31:0] issue_vk,
    input  logic [3:0]  issue_qj,
    input  logic [3:0]  issue_qk,
    output logic        issue_ready,
    output logic [3:0]  issue_tag,
    input  logic [31:0] cdb_data,
    input  logic [3:0]  cdb_tag,
    input  logic        cdb_valid,
    output logic        fu_valid,
    input  logic        fu_ready,
    output logic [2:0]  fu_op,
    output logic [31:0] fu_a,
    output logic [31:0] fu_b,
    output logic [3:0]  fu_tag
);
    localparam logic [1:0] FREE = 2'd0, WAIT = 2'd1, READY = 2'd2;

    logic [1:0]  state_q [NUM_ENTRIES];
    logic [1:0]  state_d [NUM_ENTRIES];
    logic [2:0]  op_q    [NUM_ENTRIES];
    logic [2:0]  op_d    [NUM_ENTRIES];
    logic [31:0] vj_q    [NUM_ENTRIES];
    logic [31:0] vj_d    [NUM_ENTRIES];
    logic [31:0] vk_q    [NUM_ENTRIES];
    logic [31:0] vk_d    [NUM_ENTRIES];
    logic [3:0]  qj_q    [NUM_ENTRIES];
    logic [3:0]  qj_d    [NUM_ENTRIES];
    logic [3:0]  qk_q    [NUM_ENTRIES];
    logic [3:0]  qk_d    [NUM_ENTRIES];

    logic [3:0]  issue_idx, disp_idx;
    logic        issue_fire, disp_fire, cdb_hit;
    logic [31:0] in_vj, in_vk;
    logic [3:0]  in_qj, in_qk;

    // Lowest-index FREE and READY entries; scanning downward leaves the lowest hit.
    always_comb begin
        issue_ready = 1'b0;
        issue_idx   = '0;
        fu_valid    = 1'b0;
        disp_idx    = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                issue_ready = 1'b1;
                issue_idx   = 4'(i);
            end
            if (state_q[i] == READY) begin
                fu_valid = 1'b1;
                disp_idx = 4'(i);
            end
        end
        issue_tag = 4'(TAG_BASE) + issue_idx;
        fu_op     = fu_valid ? op_q[disp_idx] : '0;
        fu_a      = fu_valid ? vj_q[disp_idx] : '0;
        fu_b      = fu_valid ? vk_q[disp_idx] : '0;
        fu_tag    = fu_valid ? 4'(TAG_BASE) + disp_idx : '0;
    end

    assign issue_fire = issue_valid && issue_ready;
    assign disp_fire  = fu_valid && fu_ready;
    assign cdb_hit    = cdb_valid && (cdb_tag != 4'd0);

`ifdef RS_ISSUE_BYPASS_EN
    // Forward a broadcast that coincides with issue straight into the new entry.
    assign in_qj = (cdb_hit && issue_qj == cdb_tag) ? 4'd0 : issue_qj;
    assign in_qk = (cdb_hit && issue_qk == cdb_tag) ? 4'd0 : issue_qk;
    assign in_vj = (cdb_hit && issue_qj == cdb_tag) ? cdb_data : issue_vj;
    assign in_vk = (cdb_hit && issue_qk == cdb_tag) ? cdb_data : issue_vk;
`else
    assign in_qj = issue_qj;
    assign in_qk = issue_qk;
    assign in_vj = issue_vj;
    assign in_vk = issue_vk;
`endif

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            state_d[i] = state_q[i];
            op_d[i]    = op_q[i];
            vj_d[i]    = vj_q[i];
            vk_d[i]    = vk_q[i];
            qj_d[i]    = qj_q[i];
            qk_d[i]    = qk_q[i];
            if (state_q[i] == WAIT) begin
                if (cdb_hit && qj_q[i] == cdb_tag) begin
                    vj_d[i] = cdb_data;
                    qj_d[i] = 4'd0;
                end
                if (cdb_hit && qk_q[i] == cdb_tag) begin
                    vk_d[i] = cdb_data;
                    qk_d[i] = 4'd0;
                end
                state_d[i] = (qj_d[i] == 4'd0 && qk_d[i] == 4'd0) ? READY : WAIT;
            end
            if (issue_fire && issue_idx == 4'(i)) begin
                op_d[i]    = issue_op;
                vj_d[i]    = in_vj;
                vk_d[i]    = in_vk;
                qj_d[i]    = in_qj;
                qk_d[i]    = in_qk;
                state_d[i] = (in_qj == 4'd0 && in_qk == 4'd0) ? READY : WAIT;
            end
            if (disp_fire && disp_idx == 4'(i))
                state_d[i] = FREE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= FREE;
                op_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                op_q[i]    <= op_d[i];
                vj_q[i]    <= vj_d[i];
                vk_q[i]    <= vk_d[i];
                qj_q[i]    <= qj_d[i];
                qk_q[i]    <= qk_d[i];
            end
        end
    end
endmodule
